ma_lsu_dphase: RTL and testbench
================================

Name: ma_lsu_dphase

Overview:
- Memory-access stage data-phase unit, directly downstream of the execute stage.
- Consumes the EXMA registers (instruction validity, function, destination, result/address) and the execute-stage address-phase approval.
- Completes the AHB3-Lite data phase: wait-state stalling, load alignment/extension, bus-error capture.
- Writes the MAWB result register that feeds the writeback stage and the execute-stage forwarding path.
- Single replica; the parent instantiates one per protection replica.

Parameters:
- BUS_W, 32, data-bus and result width (only 32 supported).
- RF_W, 5, destination register address width.

Ports:
- s_clk_i  in  1  clock.
- s_rst_i  in  1  synchronous reset, active-high.
- s_flush_i  in  1  kill the instruction currently in MA.
- s_ma_valid_i  in  1  EXMA holds a valid instruction.
- s_ma_lsu_i  in  1  EXMA instruction is a load/store.
- s_ma_f_i  in  4  function: [3] write, [2] unsigned load, [1:0] size (00 byte, 01 half, 10 word).
- s_ma_rd_i  in  RF_W  destination register.
- s_ma_val_i  in  32  EX result; transfer address for LSU instructions.
- s_lsu_approve_i  in  1  EX issued an address phase this cycle.
- s_hready_i  in  1  AHB HREADY.
- s_hresp_i  in  1  AHB HRESP (1 = ERROR).
- s_hrdata_i  in  32  AHB HRDATA.
- s_stall_o  out  1  stall the EX stage and everything upstream.
- s_mawb_val_o  out  32  registered result.
- s_mawb_rd_o  out  RF_W  registered destination.
- s_mawb_we_o  out  1  registered register-file write enable.
- s_exc_o  out  1  one-cycle bus-fault pulse, registered.
- s_exc_code_o  out  2  01 load fault, 10 store fault, 00 none.

Behaviour:
- Reset (s_rst_i=1 at an edge): state=IDLE; all outputs 0; s_stall_o=0.
- The reset overrides everything, including a data phase in flight. The bus-side pending flag is also cleared.

States:
- IDLE: no data phase outstanding.
- DPHASE: data phase outstanding for the MA instruction.
- ERR: first ERROR-response cycle was seen (hresp=1, hready=0).
- Also DISCARD, a flag on DPHASE/ERR: the owning instruction was flushed, but the transfer must still finish.

Transitions:
- IDLE -> DPHASE when s_lsu_approve_i=1 and s_hready_i=1.
- DPHASE, hready=0, hresp=0: stay in DPHASE; s_stall_o=1.
- DPHASE, hready=0, hresp=1: go to ERR; s_stall_o=1.
- DPHASE, hready=1, hresp=0: complete. Next state is DPHASE if s_lsu_approve_i=1 (back-to-back), else IDLE.
- ERR, hready=1, hresp=1: complete with fault; go to IDLE. A new approval in this cycle is ignored, because EX is stalled until the fault is taken.
- ERR with hready=0: protocol violation; stay in ERR with the stall held.

Load result (registered at completion):
- sh = addr[1:0]*8; raw = hrdata >> sh.
- Byte: raw[7:0], sign-extended from bit 7 unless f[2]=1.
- Half: raw[15:0], sign-extended from bit 15 unless f[2]=1.
- Word: hrdata.
- Misaligned accesses never reach this block (EX filters them).

MAWB register updates:
- Loaded only when s_stall_o=0.
- Non-LSU valid instruction: val <= s_ma_val_i; we <= (rd!=0). Latency 1 cycle.
- Load completing OK: val <= aligned data; we <= (rd!=0). Latency 1 cycle after the hready=1 edge.
- Store completing OK: we <= 0; val is unchanged.
- Fault completion: we <= 0; s_exc_o <= 1 for one cycle; code 01 for a load, 10 for a store.
- Otherwise (no valid instruction, or stalled): we <= 0.

Flush:
- Flush with no data phase: the MA instruction produces we=0.
- Flush during DPHASE/ERR: set DISCARD. The stall continues until hready=1, and the completion writes neither we nor exc.
- DISCARD clears on completion.
- Flush and completion in the same cycle: the result is discarded.
- s_stall_o is combinational: asserted when (state is DPHASE or ERR) and the transfer is not completing this cycle.

Test Plan:
- Word load from 0x1000, hrdata=0xDEADBEEF, 0 wait states, rd=5 -> next cycle mawb_val=0xDEADBEEF, we=1, rd=5; stall never asserted.
- Signed byte load from addr 0x1003, hrdata=0x80123456 -> mawb_val=0xFFFFFF80. Same access with f[2]=1 -> 0x00000080. Half load from 0x1002, unsigned -> 0x00008012.
- Load with 3 wait states -> s_stall_o=1 for exactly 3 cycles; result registered 1 cycle after the hready=1 cycle; no duplicate write.
- Store with ERROR response (hresp=1/hready=0, then hresp=1/hready=1) -> stall for 1 cycle; exc=1, code=10 for one cycle; we=0.
- Flush during the 2nd of 4 wait states -> stall held until hready=1; no we, no exc; state returns to IDLE.
- Back-to-back loads (approve=1 in the completion cycle) -> consecutive we pulses with correct data. Also: reset asserted mid-DPHASE -> all outputs 0 and stall=0 on the next cycle.

Source files
------------

// File: rtl/ma_lsu_dphase.sv
// Memory-access stage data-phase unit: tracks the outstanding AHB3-Lite data phase,
// aligns/extends load data, captures bus faults and registers the MAWB result.
module ma_lsu_dphase #(
    parameter int BUS_W = 32,
    parameter int RF_W  = 5
) (
    input  logic             s_clk_i,
    input  logic             s_rst_i,
    input  logic             s_flush_i,
    input  logic             s_ma_valid_i,
    input  logic             s_ma_lsu_i,
    input  logic [3:0]       s_ma_f_i,
    input  logic [RF_W-1:0]  s_ma_rd_i,
    input  logic [BUS_W-1:0] s_ma_val_i,
    input  logic             s_lsu_approve_i,
    input  logic             s_hready_i,
    input  logic             s_hresp_i,
    input  logic [BUS_W-1:0] s_hrdata_i,
    output logic             s_stall_o,
    output logic [BUS_W-1:0] s_mawb_val_o,
    output logic [RF_W-1:0]  s_mawb_rd_o,
    output logic             s_mawb_we_o,
    output logic             s_exc_o,
    output logic [1:0]       s_exc_code_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DPHASE = 2'd1,
        ST_ERR    = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              discard_q, discard_d;
    logic [BUS_W-1:0]  mawb_val_q, mawb_val_d;
    logic [RF_W-1:0]   mawb_rd_q, mawb_rd_d;
    logic              mawb_we_q, mawb_we_d;
    logic              exc_q, exc_d;
    logic [1:0]        exc_code_q, exc_code_d;

    logic busy_s, complete_s, fault_s, stall_s, kill_s;

    // Shift the addressed lane down, then sign- or zero-extend to the access size.
    function automatic logic [BUS_W-1:0] align_load(input logic [3:0]       f,
                                                    input logic [1:0]       addr_lo,
                                                    input logic [BUS_W-1:0] data);
        logic [BUS_W-1:0] raw;
        logic [BUS_W-1:0] res;
        raw = data >> {addr_lo, 3'b000};
        case (f[1:0])
            2'b00:   res = {{(BUS_W-8){raw[7] & ~f[2]}}, raw[7:0]};
            2'b01:   res = {{(BUS_W-16){raw[15] & ~f[2]}}, raw[15:0]};
            default: res = data;
        endcase
        return res;
    endfunction

    // Data-phase tracking: completion, fault detection, stall and discard flag.
    always_comb begin
        state_d    = state_q;
        discard_d  = 1'b0;
        busy_s     = (state_q != ST_IDLE);
        complete_s = busy_s && s_hready_i;
        fault_s    = complete_s && ((state_q == ST_ERR) || s_hresp_i);
        stall_s    = busy_s && !complete_s;
        kill_s     = s_flush_i || discard_q;
        if (stall_s) begin
            discard_d = discard_q || s_flush_i;
        end else begin
            discard_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (s_lsu_approve_i && s_hready_i) begin
                    state_d = ST_DPHASE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DPHASE: begin
                if (!s_hready_i) begin
                    state_d = s_hresp_i ? ST_ERR : ST_DPHASE;
                end else if (!s_hresp_i && s_lsu_approve_i) begin
                    state_d = ST_DPHASE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR: begin
                // EX stays stalled until the fault is taken, so no new approval is accepted here.
                if (s_hready_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ERR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // MAWB result, write enable and fault pulse for the instruction leaving MA.
    always_comb begin
        mawb_val_d = mawb_val_q;
        mawb_rd_d  = mawb_rd_q;
        mawb_we_d  = 1'b0;
        exc_d      = 1'b0;
        exc_code_d = 2'b00;
        if (stall_s) begin
            mawb_we_d = 1'b0;
        end else if (complete_s) begin
            if (kill_s) begin
                mawb_we_d = 1'b0;
            end else if (fault_s) begin
                exc_d      = 1'b1;
                exc_code_d = s_ma_f_i[3] ? 2'b10 : 2'b01;
            end else if (!s_ma_f_i[3]) begin
                mawb_val_d = align_load(s_ma_f_i, s_ma_val_i[1:0], s_hrdata_i);
                mawb_rd_d  = s_ma_rd_i;
                mawb_we_d  = (s_ma_rd_i != {RF_W{1'b0}});
            end else begin
                mawb_we_d = 1'b0;
            end
        end else if (s_ma_valid_i && !s_ma_lsu_i && !s_flush_i) begin
            mawb_val_d = s_ma_val_i;
            mawb_rd_d  = s_ma_rd_i;
            mawb_we_d  = (s_ma_rd_i != {RF_W{1'b0}});
        end else begin
            mawb_we_d = 1'b0;
        end
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge s_clk_i) begin
        if (s_rst_i) begin
            state_q    <= ST_IDLE;
            discard_q  <= 1'b0;
            mawb_val_q <= {BUS_W{1'b0}};
            mawb_rd_q  <= {RF_W{1'b0}};
            mawb_we_q  <= 1'b0;
            exc_q      <= 1'b0;
            exc_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            discard_q  <= discard_d;
            mawb_val_q <= mawb_val_d;
            mawb_rd_q  <= mawb_rd_d;
            mawb_we_q  <= mawb_we_d;
            exc_q      <= exc_d;
            exc_code_q <= exc_code_d;
        end
    end

    assign s_stall_o    = stall_s;
    assign s_mawb_val_o = mawb_val_q;
    assign s_mawb_rd_o  = mawb_rd_q;
    assign s_mawb_we_o  = mawb_we_q;
    assign s_exc_o      = exc_q;
    assign s_exc_code_o = exc_code_q;

endmodule

// File: tb/tb_ma_lsu_dphase.sv
// Directed bench for ma_lsu_dphase: loads, stores, wait states, faults, flush and reset.
module tb_ma_lsu_dphase;

    logic        clk = 1'b0;
    logic        rst, flush, valid, lsu, approve, hready, hresp;
    logic [3:0]  f;
    logic [4:0]  rd;
    logic [31:0] val, hrdata;
    logic        stall, we, exc;
    logic [31:0] mawb_val;
    logic [4:0]  mawb_rd;
    logic [1:0]  exc_code;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ma_lsu_dphase #(.BUS_W(32), .RF_W(5)) dut (
        .s_clk_i(clk), .s_rst_i(rst), .s_flush_i(flush),
        .s_ma_valid_i(valid), .s_ma_lsu_i(lsu), .s_ma_f_i(f), .s_ma_rd_i(rd),
        .s_ma_val_i(val), .s_lsu_approve_i(approve), .s_hready_i(hready),
        .s_hresp_i(hresp), .s_hrdata_i(hrdata), .s_stall_o(stall),
        .s_mawb_val_o(mawb_val), .s_mawb_rd_o(mawb_rd), .s_mawb_we_o(we),
        .s_exc_o(exc), .s_exc_code_o(exc_code)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 1'b0; valid = 1'b0; lsu = 1'b0; f = 4'd0; rd = 5'd0; val = 32'd0;
        approve = 1'b0; hready = 1'b1; hresp = 1'b0; hrdata = 32'd0;
    endtask

    // EX issues an address phase while MA holds a bubble.
    task automatic issue();
        idle_inputs();
        approve = 1'b1;
        #1 check("issue_stall", {31'd0, stall}, 32'd0);
        tick();
    endtask

    task automatic ma_lsu(input logic [3:0] fn, input logic [31:0] addr,
                          input logic [31:0] data, input logic [4:0] dst);
        valid = 1'b1; lsu = 1'b1; f = fn; val = addr; hrdata = data; rd = dst;
        approve = 1'b0; hready = 1'b1; hresp = 1'b0;
    endtask

    // Full OKAY transfer with a number of wait states; outputs are checked by the caller.
    task automatic xfer(input logic [3:0] fn, input logic [31:0] addr,
                        input logic [31:0] data, input logic [4:0] dst, input int waits);
        issue();
        ma_lsu(fn, addr, data, dst);
        for (int i = 0; i < waits; i++) begin
            hready = 1'b0;
            #1 check("wait_stall", {31'd0, stall}, 32'd1);
            tick();
            check("wait_we", {31'd0, we}, 32'd0);
        end
        hready = 1'b1;
        #1 check("done_stall", {31'd0, stall}, 32'd0);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        check("rst_val", mawb_val, 32'd0);
        check("rst_rd", {27'd0, mawb_rd}, 32'd0);
        check("rst_we", {31'd0, we}, 32'd0);
        check("rst_exc", {30'd0, exc_code, exc} & 32'h7, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        rst = 1'b0;

        // Non-LSU results
        valid = 1'b1; val = 32'h1234_5678; rd = 5'd7;
        tick();
        check("alu_val", mawb_val, 32'h1234_5678);
        check("alu_we", {31'd0, we}, 32'd1);
        check("alu_rd", {27'd0, mawb_rd}, 32'd7);
        val = 32'hAAAA_5555; rd = 5'd0;
        tick();
        check("alu_r0_we", {31'd0, we}, 32'd0);
        check("alu_r0_val", mawb_val, 32'hAAAA_5555);
        rd = 5'd3; flush = 1'b1;
        tick();
        check("alu_flush_we", {31'd0, we}, 32'd0);

        // Loads with zero wait states
        xfer(4'b0010, 32'h0000_1000, 32'hDEAD_BEEF, 5'd5, 0);
        check("lw_val", mawb_val, 32'hDEAD_BEEF);
        check("lw_we", {31'd0, we}, 32'd1);
        check("lw_rd", {27'd0, mawb_rd}, 32'd5);
        xfer(4'b0000, 32'h0000_1003, 32'h8012_3456, 5'd6, 0);
        check("lb_val", mawb_val, 32'hFFFF_FF80);
        xfer(4'b0100, 32'h0000_1003, 32'h8012_3456, 5'd6, 0);
        check("lbu_val", mawb_val, 32'h0000_0080);
        xfer(4'b0101, 32'h0000_1002, 32'h8012_3456, 5'd6, 0);
        check("lhu_val", mawb_val, 32'h0000_8012);
        xfer(4'b0001, 32'h0000_1002, 32'h8012_3456, 5'd6, 0);
        check("lh_val", mawb_val, 32'hFFFF_8012);

        // Load with three wait states, single write
        xfer(4'b0010, 32'h0000_2000, 32'hCAFE_F00D, 5'd9, 3);
        check("lw3_val", mawb_val, 32'hCAFE_F00D);
        check("lw3_we", {31'd0, we}, 32'd1);
        idle_inputs();
        tick();
        check("lw3_nodup", {31'd0, we}, 32'd0);

        // OKAY store leaves the result untouched
        xfer(4'b1010, 32'h0000_2004, 32'h0, 5'd0, 0);
        check("sw_we", {31'd0, we}, 32'd0);
        check("sw_val", mawb_val, 32'hCAFE_F00D);

        // Store with ERROR response
        issue();
        ma_lsu(4'b1010, 32'h0000_3000, 32'h0, 5'd0);
        hready = 1'b0; hresp = 1'b1;
        #1 check("serr_stall1", {31'd0, stall}, 32'd1);
        tick();
        check("serr_exc_early", {31'd0, exc}, 32'd0);
        hready = 1'b1;
        #1 check("serr_stall2", {31'd0, stall}, 32'd0);
        tick();
        check("serr_exc", {31'd0, exc}, 32'd1);
        check("serr_code", {30'd0, exc_code}, 32'd2);
        check("serr_we", {31'd0, we}, 32'd0);
        idle_inputs();
        tick();
        check("serr_pulse", {31'd0, exc}, 32'd0);

        // Load with ERROR response
        issue();
        ma_lsu(4'b0010, 32'h0000_3004, 32'h0, 5'd4);
        hready = 1'b0; hresp = 1'b1;
        tick();
        hready = 1'b1;
        tick();
        check("lerr_exc", {31'd0, exc}, 32'd1);
        check("lerr_code", {30'd0, exc_code}, 32'd1);
        check("lerr_we", {31'd0, we}, 32'd0);

        // Flush during the second of four wait states
        issue();
        ma_lsu(4'b0010, 32'h0000_5000, 32'h5555_AAAA, 5'd8);
        hready = 1'b0;
        tick();
        flush = 1'b1;
        #1 check("fl_stall2", {31'd0, stall}, 32'd1);
        tick();
        idle_inputs();
        hready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1 check("fl_stall_hold", {31'd0, stall}, 32'd1);
            tick();
        end
        hready = 1'b1; hrdata = 32'h5555_AAAA;
        #1 check("fl_done_stall", {31'd0, stall}, 32'd0);
        tick();
        check("fl_we", {31'd0, we}, 32'd0);
        check("fl_exc", {31'd0, exc}, 32'd0);
        hready = 1'b0;
        #1 check("fl_idle", {31'd0, stall}, 32'd0);
        tick();

        // Back-to-back loads
        issue();
        ma_lsu(4'b0010, 32'h0000_4000, 32'h1111_2222, 5'd10);
        approve = 1'b1;
        #1 check("b2b_stall", {31'd0, stall}, 32'd0);
        tick();
        check("b2b_we1", {31'd0, we}, 32'd1);
        check("b2b_val1", mawb_val, 32'h1111_2222);
        ma_lsu(4'b0100, 32'h0000_4001, 32'h0000_AB00, 5'd11);
        tick();
        check("b2b_we2", {31'd0, we}, 32'd1);
        check("b2b_val2", mawb_val, 32'h0000_00AB);
        check("b2b_rd2", {27'd0, mawb_rd}, 32'd11);

        // Reset in the middle of a data phase
        issue();
        ma_lsu(4'b0010, 32'h0000_6000, 32'h0, 5'd12);
        hready = 1'b0;
        #1 check("mr_stall", {31'd0, stall}, 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        hready = 1'b0;
        check("mr_val", mawb_val, 32'd0);
        check("mr_rd", {27'd0, mawb_rd}, 32'd0);
        check("mr_we", {31'd0, we}, 32'd0);
        check("mr_exc", {29'd0, exc_code, exc}, 32'd0);
        #1 check("mr_stall_clr", {31'd0, stall}, 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
